// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem handshake, one-entry stall buffer, IF/ID register.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        If_Id_Write,
  input  logic        beq_pc_sel,
  input  logic [31:0] branch_target,
  input  logic        If_id_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] If_Id_pc,
  output logic [31:0] If_Id_instr,
  output logic        If_Id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, req_addr, req_nxt, tgt, seq_addr;
  fetch_t      hold_buf, new_data;
  logic        new_vld, hold_ld, drop;

  assign tgt      = {branch_target[31:2], 2'b00};
  assign seq_addr = req_addr + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = req_addr;
    new_vld   = 1'b0;
    new_data  = {req_addr, imem_rdata};
    hold_ld   = 1'b0;
    drop      = 1'b0;
    unique case (state)
      FETCH: begin
        if (imem_rvalid) begin
          if (beq_pc_sel) begin
            pc_nxt  = tgt;
            req_nxt = tgt;
            drop    = 1'b1;
          end else if (If_Id_Write) begin
            new_vld = 1'b1;
            pc_nxt  = seq_addr;
            req_nxt = seq_addr;
          end else begin
            hold_ld   = 1'b1;
            pc_nxt    = seq_addr;
            state_nxt = HOLD;
          end
        end else if (beq_pc_sel) begin
          // request still in flight: remember the target, retire the old response first
          pc_nxt    = tgt;
          state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (beq_pc_sel) begin
          pc_nxt    = tgt;
          req_nxt   = tgt;
          drop      = 1'b1;
          state_nxt = FETCH;
        end else if (If_Id_Write) begin
          new_vld   = 1'b1;
          new_data  = hold_buf;
          req_nxt   = pc;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (beq_pc_sel) pc_nxt = tgt;
        if (imem_rvalid) begin
          req_nxt   = beq_pc_sel ? tgt : pc;
          drop      = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // reset gates the request so memory never sees a fetch while reset is held
  always_comb begin
    imem_req  = (state != HOLD) && !reset;
    imem_addr = req_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      hold_buf    <= '0;
      If_Id_pc    <= '0;
      If_Id_instr <= NOP_INSTR;
      If_Id_valid <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      req_addr <= req_nxt;
      if (hold_ld) hold_buf <= {req_addr, imem_rdata};
      if (If_Id_Write) begin
        if (If_id_flush || !new_vld) begin
          If_Id_instr <= NOP_INSTR;
          If_Id_valid <= 1'b0;
        end else begin
          If_Id_pc    <= new_data.pc;
          If_Id_instr <= new_data.instr;
          If_Id_valid <= 1'b1;
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (new_vld && !If_id_flush)           perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop || (new_vld && If_id_flush))  perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory responder returns addr|0x13 after a programmable latency.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        If_Id_Write = 1'b1;
  logic        beq_pc_sel = 1'b0;
  logic [31:0] branch_target = '0;
  logic        If_id_flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] If_Id_pc;
  logic [31:0] If_Id_instr;
  logic        If_Id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int lat = 1;
  int age = 0;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .If_Id_Write(If_Id_Write), .beq_pc_sel(beq_pc_sel),
    .branch_target(branch_target), .If_id_flush(If_id_flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .If_Id_pc(If_Id_pc), .If_Id_instr(If_Id_instr), .If_Id_valid(If_Id_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // responder: a request seen for more than lat negedges gets one rvalid cycle
  always @(negedge clk) begin
    if (reset) begin
      age = 0;
      imem_rvalid = 1'b0;
    end else if (imem_rvalid) begin
      imem_rvalid = 1'b0;
      age = imem_req ? 1 : 0;
    end else if (imem_req) begin
      age = age + 1;
      if (age > lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = imem_addr | 32'h13;
      end
    end else begin
      age = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_resp(input logic [31:0] a, input string nm);
    int n = 0;
    while (!(imem_rvalid && imem_addr == a) && n < 50) begin
      tick();
      n++;
    end
    n_chk++;
    if (n >= 50) begin n_fail++; $display("FAIL %s: no response for addr %h", nm, a); end
  endtask

  task automatic redirect(input logic [31:0] t);
    beq_pc_sel = 1'b1;
    branch_target = t;
    tick();
    beq_pc_sel = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_chk++; if (If_Id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", If_Id_pc); end
    n_chk++; if (If_Id_instr !== 32'h13) begin n_fail++; $display("FAIL rst_instr: got %h want 13", If_Id_instr); end
    n_chk++; if (If_Id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", If_Id_valid); end
    reset = 1'b0;
    tick();
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_fetch();
    wait_resp(32'h0, "fetch0");
    tick();
    n_chk++; if (If_Id_pc !== 32'h0 || If_Id_instr !== 32'h13 || If_Id_valid !== 1'b1) begin
      n_fail++; $display("FAIL fetch0_ifid: got %h/%h/%b want 0/13/1", If_Id_pc, If_Id_instr, If_Id_valid); end
    n_chk++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL fetch_next: got %h want 4", imem_addr); end
    tick();
    n_chk++; if (If_Id_valid !== 1'b0 || If_Id_instr !== 32'h13) begin
      n_fail++; $display("FAIL bubble: got %b/%h want 0/13", If_Id_valid, If_Id_instr); end
    wait_resp(32'h4, "fetch4");
    tick();
    n_chk++; if (If_Id_pc !== 32'h4 || If_Id_instr !== 32'h17 || If_Id_valid !== 1'b1) begin
      n_fail++; $display("FAIL fetch4_ifid: got %h/%h/%b want 4/17/1", If_Id_pc, If_Id_instr, If_Id_valid); end
  endtask

  task automatic test_stall();
    wait_resp(32'h8, "stall8");
    If_Id_Write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem_req); end
      n_chk++; if (If_Id_valid !== 1'b0 || If_Id_instr !== 32'h13) begin
        n_fail++; $display("FAIL hold_ifid[%0d]: got %b/%h want 0/13", i, If_Id_valid, If_Id_instr); end
    end
    If_Id_Write = 1'b1;
    tick();
    n_chk++; if (If_Id_pc !== 32'h8 || If_Id_instr !== 32'h1b || If_Id_valid !== 1'b1) begin
      n_fail++; $display("FAIL release_ifid: got %h/%h/%b want 8/1b/1", If_Id_pc, If_Id_instr, If_Id_valid); end
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'hc) begin
      n_fail++; $display("FAIL release_req: got %b/%h want 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_drain();
    lat = 3;
    wait_resp(32'hc, "drain12");
    tick();
    n_chk++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL drain_req16: got %h want 10", imem_addr); end
    tick();
    redirect(32'h40);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_fail++; $display("FAIL drain_stable: got %b/%h want 1/10", imem_req, imem_addr); end
    wait_resp(32'h10, "drain16");
    tick();
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL drain_target: got %b/%h want 1/40", imem_req, imem_addr); end
    n_chk++; if (If_Id_valid !== 1'b0 || If_Id_instr !== 32'h13) begin
      n_fail++; $display("FAIL drain_dropped: got %b/%h want 0/13", If_Id_valid, If_Id_instr); end
  endtask

  task automatic test_flush_redirect();
    lat = 1;
    wait_resp(32'h40, "fr40");
    tick();
    n_chk++; if (If_Id_pc !== 32'h40 || If_Id_instr !== 32'h53 || If_Id_valid !== 1'b1) begin
      n_fail++; $display("FAIL fr40_ifid: got %h/%h/%b want 40/53/1", If_Id_pc, If_Id_instr, If_Id_valid); end
    redirect(32'h17);
    n_chk++; if (imem_addr !== 32'h44) begin n_fail++; $display("FAIL fr_drain44: got %h want 44", imem_addr); end
    tick();
    n_chk++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL fr_mask17: got %h want 14", imem_addr); end
    wait_resp(32'h14, "fr20");
    If_id_flush = 1'b1;
    redirect(32'h43);
    If_id_flush = 1'b0;
    n_chk++; if (If_Id_valid !== 1'b0 || If_Id_instr !== 32'h13) begin
      n_fail++; $display("FAIL fr_squash: got %b/%h want 0/13", If_Id_valid, If_Id_instr); end
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL fr_mask43: got %b/%h want 1/40", imem_req, imem_addr); end
`ifdef IF_PERF_CNT_EN
    n_chk++; if (perf_drop_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_drop: got %0d want 3", perf_drop_cnt); end
    n_chk++; if (perf_fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_fetch: got %0d want 5", perf_fetch_cnt); end
`endif
  endtask

  task automatic test_wrap();
    redirect(32'hffff_ffff);
    wait_resp(32'hffff_fffc, "wrap");
    tick();
    n_chk++; if (If_Id_pc !== 32'hffff_fffc || If_Id_instr !== 32'hffff_ffff || If_Id_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_ifid: got %h/%h/%b want fffffffc/ffffffff/1", If_Id_pc, If_Id_instr, If_Id_valid); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_flush_only();
    wait_resp(32'h0, "flush0");
    If_id_flush = 1'b1;
    tick();
    If_id_flush = 1'b0;
    n_chk++; if (If_Id_valid !== 1'b0 || If_Id_instr !== 32'h13) begin
      n_fail++; $display("FAIL flush_squash: got %b/%h want 0/13", If_Id_valid, If_Id_instr); end
    n_chk++; if (If_Id_pc !== 32'hffff_fffc) begin n_fail++; $display("FAIL flush_pc: got %h want fffffffc", If_Id_pc); end
    n_chk++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL flush_next: got %h want 4", imem_addr); end
  endtask

  task automatic test_reset_mid_drain();
    lat = 3;
    tick();
    redirect(32'h80);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_fail++; $display("FAIL mid_drain: got %b/%h want 1/4", imem_req, imem_addr); end
    reset = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b want 0", imem_req); end
    n_chk++; if (If_Id_pc !== 32'h0 || If_Id_instr !== 32'h13 || If_Id_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ifid: got %h/%h/%b want 0/13/0", If_Id_pc, If_Id_instr, If_Id_valid); end
    tick();
    reset = 1'b0;
    lat = 1;
    tick();
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_resume: got %b/%h want 1/0", imem_req, imem_addr); end
    wait_resp(32'h0, "mid0");
    tick();
    n_chk++; if (If_Id_pc !== 32'h0 || If_Id_instr !== 32'h13 || If_Id_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_ifid: got %h/%h/%b want 0/13/1", If_Id_pc, If_Id_instr, If_Id_valid); end
    n_chk++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL mid_next: got %h want 4", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_drain();
    test_flush_redirect();
    test_wrap();
    test_flush_only();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
